// File: rtl/lb_ctrl.sv
// Line-buffer sequencing controller: fills FILTER_SIZE line buffers in rotating
// order, then sweeps the column address to present one window per column.
module lb_ctrl #(
    parameter int FILTER_SIZE     = 5,
    parameter int LINE_WIDTH      = 28,
    parameter int LINES_PER_FRAME = 28
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [15:0]            in_data,
    output logic                   in_ready,
    output logic [FILTER_SIZE-1:0] lb_wr_en,
    output logic [15:0]            lb_wr_data,
    output logic [FILTER_SIZE-1:0] lb_rd_en,
    output logic [6:0]             lb_rd_addr,
    input  logic [FILTER_SIZE-1:0] lb_full,
    input  logic [FILTER_SIZE-1:0] lb_data_valid,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [6:0]             win_col,
    output logic [2:0]             win_top,
    output logic                   frame_done,
    output logic                   err
);
    localparam int RW = $clog2(LINES_PER_FRAME + 1);
    localparam logic [6:0]    LAST_WORD = 7'(LINE_WIDTH / 2 - 1);
    localparam logic [6:0]    LAST_COL  = 7'(LINE_WIDTH - FILTER_SIZE);
    localparam logic [2:0]    LAST_PTR  = 3'(FILTER_SIZE - 1);
    localparam logic [3:0]    RES_FULL  = 4'(FILTER_SIZE);
    localparam logic [RW-1:0] ROWS_END  = RW'(LINES_PER_FRAME);

    typedef enum logic [3:0] {
        S_IDLE, S_FILL_REQ, S_FILL, S_FILL_END, S_GAP,
        S_RD_REQ, S_RD_ADDR, S_RD_WAIT, S_WIN, S_ROTATE
    } state_t;

    state_t state, state_nxt;

    logic [6:0]    word_cnt;
    logic [6:0]    col;
    logic [2:0]    wr_ptr;
    logic [2:0]    top_ptr;
    logic [3:0]    resident;
    logic [RW-1:0] rows_in;
    logic          err_q;

    logic                   word_inc, gap_step, col_clr, col_inc, rot, err_set;
    logic [3:0]             res_inc;
    logic                   frame_end;
    logic [FILTER_SIZE-1:0] full_shift;

    assign err = err_q;

    always_comb begin
        res_inc    = (resident == RES_FULL) ? RES_FULL : resident + 4'd1;
        frame_end  = (rows_in == ROWS_END);
        full_shift = lb_full >> wr_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // All outputs are decoded from the state and forced quiet while rst is high.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        lb_wr_en   = '0;
        lb_wr_data = '0;
        lb_rd_en   = '0;
        lb_rd_addr = '0;
        win_valid  = 1'b0;
        win_col    = '0;
        win_top    = '0;
        frame_done = 1'b0;
        word_inc   = 1'b0;
        gap_step   = 1'b0;
        col_clr    = 1'b0;
        col_inc    = 1'b0;
        rot        = 1'b0;
        err_set    = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: if (in_valid) state_nxt = S_FILL_REQ;
                S_FILL_REQ: begin
                    lb_wr_en  = FILTER_SIZE'(1) << wr_ptr;
                    state_nxt = S_FILL;
                end
                S_FILL: begin
                    in_ready   = 1'b1;
                    lb_wr_data = in_valid ? in_data : '0;
                    err_set    = !in_valid;
                    word_inc   = 1'b1;
                    if (word_cnt == LAST_WORD) state_nxt = S_FILL_END;
                end
                S_FILL_END: begin
                    err_set   = !full_shift[0];
                    state_nxt = S_GAP;
                end
                S_GAP: begin
                    gap_step = 1'b1;
                    if (res_inc == RES_FULL) begin
                        col_clr   = 1'b1;
                        state_nxt = S_RD_REQ;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    lb_rd_en   = '1;
                    lb_rd_addr = col;
                    state_nxt  = S_RD_ADDR;
                end
                S_RD_ADDR: begin
                    lb_rd_addr = col;
                    state_nxt  = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    err_set   = (lb_data_valid != '1);
                    state_nxt = S_WIN;
                end
                S_WIN: begin
                    win_valid = 1'b1;
                    win_col   = col;
                    win_top   = top_ptr;
                    if (win_ready) begin
                        if (col < LAST_COL) begin
                            col_inc   = 1'b1;
                            state_nxt = S_RD_REQ;
                        end else begin
                            state_nxt = S_ROTATE;
                        end
                    end
                end
                S_ROTATE: begin
                    rot        = 1'b1;
                    frame_done = frame_end;
                    state_nxt  = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
            col      <= '0;
            wr_ptr   <= '0;
            top_ptr  <= '0;
            resident <= '0;
            rows_in  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (word_inc) word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 7'd1;
            if (gap_step) begin
                wr_ptr   <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 3'd1;
                rows_in  <= rows_in + 1'b1;
                resident <= res_inc;
            end
            if (col_clr)      col <= '0;
            else if (col_inc) col <= col + 7'd1;
            if (rot) begin
                if (frame_end) begin
                    rows_in  <= '0;
                    resident <= '0;
                    wr_ptr   <= '0;
                    top_ptr  <= '0;
                end else begin
                    top_ptr <= (top_ptr == LAST_PTR) ? '0 : top_ptr + 3'd1;
                end
            end
            if (err_set) err_q <= 1'b1;
        end
    end
endmodule

// File: doc/lb_ctrl.md
Name: lb_ctrl

Overview:
- Sequencing controller for an array of FILTER_SIZE line buffers feeding the convolution engine.
- Streams incoming pixel lines (2 pixels per 16-bit word) into the line buffers in rotating order.
- Once FILTER_SIZE lines are resident, sweeps the column address to produce one FILTER_SIZE x FILTER_SIZE window per column position.
- Tracks frame progress and flags protocol errors.

Parameters:
- FILTER_SIZE, 5, number of line buffers and window height/width.
- LINE_WIDTH, 28, pixels per line; must be even and at most 127.
- LINES_PER_FRAME, 28, lines per frame; must be at least FILTER_SIZE.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  source word valid.
- in_data  in  16  two pixels; [7:0] is the lower column.
- in_ready  out  1  controller consumes in_data this cycle.
- lb_wr_en  out  FILTER_SIZE  one-hot write-start strobe to line buffer i.
- lb_wr_data  out  16  word to line buffers (broadcast).
- lb_rd_en  out  FILTER_SIZE  read-start strobe; all bits asserted together.
- lb_rd_addr  out  7  window start column (broadcast).
- lb_full  in  FILTER_SIZE  per-buffer line-complete flag.
- lb_data_valid  in  FILTER_SIZE  per-buffer read data valid.
- win_valid  out  1  all line buffer rd_data outputs hold the window for win_col.
- win_ready  in  1  downstream accepts window.
- win_col  out  7  column of the current window.
- win_top  out  3  index of the line buffer holding the oldest (top) row.
- frame_done  out  1  one-cycle pulse after the last window of the frame.
- err  out  1  sticky error; cleared only by rst.

Behaviour:
- Reset values: all outputs 0; internal counters 0; wr_ptr=0; top_ptr=0; state S_IDLE. During rst all strobes are held low.
  - rst mid-operation aborts immediately.
  - Line buffer contents are undefined afterwards, so a new frame starts from scratch.
- States:
  - S_IDLE
  - S_FILL_REQ
  - S_FILL
  - S_FILL_END
  - S_GAP
  - S_RD_REQ
  - S_RD_ADDR
  - S_RD_WAIT
  - S_WIN
  - S_ROTATE
- S_IDLE: on in_valid=1, go to S_FILL_REQ.
- S_FILL_REQ: lb_wr_en[wr_ptr]=1 for one cycle; go to S_FILL.
- S_FILL: in_ready=1 for exactly LINE_WIDTH/2 consecutive cycles, with lb_wr_data=in_data.
  - The line buffer writes every cycle and cannot stall.
  - If in_valid=0 in any of these cycles: write 16'h0000 and set err.
  - After the last word, go to S_FILL_END.
- S_FILL_END: sample lb_full[wr_ptr]; if 0, set err. Go to S_GAP.
- S_GAP: one idle cycle for line buffer recovery.
  - Increment wr_ptr (mod FILTER_SIZE) and rows_in.
  - If fewer than FILTER_SIZE lines are resident, go to S_IDLE; otherwise start the sweep with col=0 in S_RD_REQ.
- S_RD_REQ: lb_rd_en all ones for one cycle; lb_rd_addr=col.
  - lb_rd_addr holds col through S_RD_ADDR, because the line buffer samples the address one cycle after rd_en.
- S_RD_ADDR: go to S_RD_WAIT.
- S_RD_WAIT: wait until lb_data_valid is all ones.
  - Normally this is the first S_RD_WAIT cycle, i.e. read latency is rd_en+2.
  - If not all ones in that cycle, set err and proceed anyway.
  - Go to S_WIN.
- S_WIN: win_valid=1, win_col=col, win_top=top_ptr.
  - Hold until win_ready=1. Line buffer rd_data is stable while no new read is issued.
  - On the handshake, if col<LINE_WIDTH-FILTER_SIZE: col++ and go to S_RD_REQ. Otherwise go to S_ROTATE.
  - Throughput is one window per 4 cycles with win_ready held high.
- S_ROTATE:
  - If rows_in==LINES_PER_FRAME: pulse frame_done; clear rows_in, resident count, wr_ptr and top_ptr.
  - Otherwise: top_ptr++ mod FILTER_SIZE; the next line overwrites the oldest buffer (wr_ptr already equals top_ptr).
  - Go to S_IDLE.
- in_ready is 0 in every state except S_FILL. Input words arriving outside a fill are not consumed and are not errors.
- Arithmetic: col is 7-bit unsigned; the sweep covers LINE_WIDTH-FILTER_SIZE+1 positions. Pointers wrap at FILTER_SIZE, not at a power of two.
- Simultaneous events: rst dominates everything. win_ready is ignored outside S_WIN.

Test Plan (FILTER_SIZE=3, LINE_WIDTH=8, LINES_PER_FRAME=4 unless noted):
- Single fill: in_valid held 1 with words 0x0201, 0x0403, 0x0605, 0x0807 -> lb_wr_en=3'b001 at cycle 1; in_ready high cycles 2-5; buffer 0 holds 1..8; lb_full[0] seen in S_FILL_END; err=0.
- Priming: three lines -> lb_wr_en sequence 001, 010, 100; first lb_rd_en=3'b111 with lb_rd_addr=0 after the third S_GAP; win_top=0.
- Sweep with win_ready=1: exactly 6 windows, win_col 0..5, spaced 4 cycles apart. With win_ready held low 10 cycles at col=2: win_valid stays 1 and win_col stays 2.
- Rotation and frame end: 4th line writes buffer 0 (lb_wr_en=001); its windows report win_top=1; frame_done pulses once after col=5 of line 4, then wr_ptr=0.
- Underrun: in_valid=0 on the 3rd fill cycle -> zero word written, err=1 and remains 1 through subsequent lines until rst.
- Reset mid-sweep: rst at col=3 -> next cycle all outputs 0, no strobes during rst; the next frame restarts with lb_wr_en=001.
